// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG TAP controller slice.
package jtag_pkg;

    // TAP controller states, encoded 0..15 in the standard 1149.1 order
    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    localparam int unsigned DEFAULT_IR_W = 4;

    // Opcodes as wide values; users truncate to IR_W (BYPASS becomes all ones)
    localparam logic [31:0] OP_EXTEST = 32'h0000_0000;
    localparam logic [31:0] OP_SAMPLE = 32'h0000_0001;
    localparam logic [31:0] OP_IDCODE = 32'h0000_0002;
    localparam logic [31:0] OP_BYPASS = 32'hFFFF_FFFF;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state register and 1149.1 TMS next-state graph.
import jtag_pkg::*;

module jtag_tap_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tms,
    output tap_state_t tapState
);

    tap_state_t nextState;

    // State register, asynchronously forced to Test-Logic-Reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tapState <= TLR;
        end else begin
            tapState <= nextState;
        end
    end

    // Next state from the current state and TMS
    always_comb begin
        nextState = tapState;
        unique case (tapState)
            TLR:    nextState = tms ? TLR    : RTI;
            RTI:    nextState = tms ? SEL_DR : RTI;
            SEL_DR: nextState = tms ? SEL_IR : CAP_DR;
            CAP_DR: nextState = tms ? EX1_DR : SH_DR;
            SH_DR:  nextState = tms ? EX1_DR : SH_DR;
            EX1_DR: nextState = tms ? UPD_DR : PAU_DR;
            PAU_DR: nextState = tms ? EX2_DR : PAU_DR;
            EX2_DR: nextState = tms ? UPD_DR : SH_DR;
            UPD_DR: nextState = tms ? SEL_DR : RTI;
            SEL_IR: nextState = tms ? TLR    : CAP_IR;
            CAP_IR: nextState = tms ? EX1_IR : SH_IR;
            SH_IR:  nextState = tms ? EX1_IR : SH_IR;
            EX1_IR: nextState = tms ? UPD_IR : PAU_IR;
            PAU_IR: nextState = tms ? EX2_IR : PAU_IR;
            EX2_IR: nextState = tms ? UPD_IR : SH_IR;
            UPD_IR: nextState = tms ? SEL_DR : RTI;
            default: nextState = TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller top: instruction register, decode, BYPASS/IDCODE
// data registers, boundary-register strobes and the tdo mux.
// Optional ID register enabled by defining JTAG_IDCODE_EN.
import jtag_pkg::*;

module jtag_tap_ctrl #(
    parameter int unsigned IR_W       = DEFAULT_IR_W,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_563F
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tms,
    input  logic            tdi,
    output logic            tdo,
    output logic            tdo_oe,
    input  logic            bsr_tdo,
    output logic            bsr_capture,
    output logic            bsr_shift,
    output logic            bsr_update,
    output logic            bsr_mode,
    output logic [IR_W-1:0] ir_q,
    output logic [3:0]      tap_state
);

    if (IR_W < 2) begin : gBadIrW
        $error("jtag_tap_ctrl: IR_W must be at least 2");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : gBadId
        $error("jtag_tap_ctrl: IDCODE_VAL bit 0 must be 1");
    end

    localparam logic [IR_W-1:0] opExtest = IR_W'(OP_EXTEST);
    localparam logic [IR_W-1:0] opSample = IR_W'(OP_SAMPLE);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] opIdcode = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] resetOp  = opIdcode;
`else
    localparam logic [IR_W-1:0] resetOp  = IR_W'(OP_BYPASS);
`endif

    tap_state_t      state;
    logic [IR_W-1:0] irSr;
    logic [IR_W-1:0] irQ;
    logic [IR_W-1:0] irCur;
    logic            bypassReg;
    logic            selBsr;
    logic            selId;
    logic            selBypass;

    jtag_tap_fsm uFsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .tms      (tms),
        .tapState (state)
    );

    // The held instruction only takes effect outside TLR, so the reset
    // opcode is visible from the first cycle spent in TLR.
    assign irCur     = (state == TLR) ? resetOp : irQ;
    assign ir_q      = irCur;
    assign tap_state = state;

    // Instruction register: capture, shift and update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irSr <= '0;
            irQ  <= resetOp;
        end else begin
            unique case (state)
                TLR:     irQ  <= resetOp;
                CAP_IR:  irSr <= IR_W'(2'b01);
                SH_IR:   irSr <= {tdi, irSr[IR_W-1:1]};
                UPD_IR:  irQ  <= irSr;
                default: ;
            endcase
        end
    end

    // Data-register selection decoded from the active instruction
    always_comb begin
        selBsr    = (irCur == opExtest) || (irCur == opSample);
`ifdef JTAG_IDCODE_EN
        selId     = (irCur == opIdcode);
`else
        selId     = 1'b0;
`endif
        selBypass = !selBsr && !selId;
        bsr_mode  = (irCur == opExtest);
    end

    // One-bit BYPASS register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypassReg <= 1'b0;
        end else if (selBypass && state == CAP_DR) begin
            bypassReg <= 1'b0;
        end else if (selBypass && state == SH_DR) begin
            bypassReg <= tdi;
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] idReg;

    // 32-bit ID register, shifted out LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idReg <= '0;
        end else if (selId && state == CAP_DR) begin
            idReg <= IDCODE_VAL;
        end else if (selId && state == SH_DR) begin
            idReg <= {tdi, idReg[31:1]};
        end
    end
`endif

    // Moore strobes, output enable and the tdo mux
    always_comb begin
        bsr_capture = selBsr && (state == CAP_DR);
        bsr_shift   = selBsr && (state == SH_DR);
        bsr_update  = selBsr && (state == UPD_DR);
        tdo_oe      = (state == SH_DR) || (state == SH_IR);
        tdo         = 1'b0;
        if (state == SH_IR) begin
            tdo = irSr[0];
        end else if (state == SH_DR) begin
            if (selBsr) begin
                tdo = bsr_tdo;
`ifdef JTAG_IDCODE_EN
            end else if (selId) begin
                tdo = idReg[0];
`endif
            end else begin
                tdo = bypassReg;
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed self-checking bench for jtag_tap_ctrl (honours JTAG_IDCODE_EN).
module tb_jtag_tap_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_oe;
    logic       bsr_tdo;
    logic       bsr_capture;
    logic       bsr_shift;
    logic       bsr_update;
    logic       bsr_mode;
    logic [3:0] ir_q;
    logic [3:0] tap_state;

    int tests  = 0;
    int failed = 0;

`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] RESET_OP = 4'h2;
`else
    localparam logic [3:0] RESET_OP = 4'hF;
`endif

    jtag_tap_ctrl #(.IR_W(4), .IDCODE_VAL(32'h1000_563F)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_oe      (tdo_oe),
        .bsr_tdo     (bsr_tdo),
        .bsr_capture (bsr_capture),
        .bsr_shift   (bsr_shift),
        .bsr_update  (bsr_update),
        .bsr_mode    (bsr_mode),
        .ir_q        (ir_q),
        .tap_state   (tap_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply tms/tdi, take one rising edge, settle 1 time unit past it
    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        #1;
    endtask

    // From RTI: scan an IR value (LSB first) and return to RTI
    task automatic loadIr(input logic [3:0] op);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i == 3, op[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    logic [31:0] pat;
    logic [31:0] got;
    logic [31:0] expWord;
    logic [3:0]  obs4;
    int          capCnt;
    int          shCnt;
    int          updCnt;
    int          bsrAny;

    initial begin
        rst_n   = 1'b0;
        tms     = 1'b1;
        tdi     = 1'b0;
        bsr_tdo = 1'b0;
        #3;
        // Reset state
        chk("rst_state", 32'(tap_state), 32'd0);
        chk("rst_ir", 32'(ir_q), 32'(RESET_OP));
        chk("rst_mode", 32'(bsr_mode), 32'd0);
        chk("rst_oe", 32'(tdo_oe), 32'd0);
        chk("rst_tdo", 32'(tdo), 32'd0);
        chk("rst_strobes", 32'({bsr_capture, bsr_shift, bsr_update}), 32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("tlr_hold", 32'(tap_state), 32'd0);

        // Reset-instruction DR read (IDCODE, or BYPASS without the ID register)
        pat = 32'hA5C3_0F96;
        step(1'b0, 1'b0);
        chk("rti", 32'(tap_state), 32'd1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("cap_dr", 32'(tap_state), 32'd3);
        chk("cap_no_bsr", 32'(bsr_capture), 32'd0);
        step(1'b0, 1'b0);
        chk("sh_dr_oe", 32'(tdo_oe), 32'd1);
        for (int i = 0; i < 32; i++) begin
            got[i] = tdo;
            step(i == 31, pat[i]);
        end
`ifdef JTAG_IDCODE_EN
        expWord = 32'h1000_563F;
`else
        expWord = {pat[30:0], 1'b0};
`endif
        chk("dr_read", got, expWord);
        chk("ex1_dr", 32'(tap_state), 32'd5);
        chk("ex1_oe", 32'(tdo_oe), 32'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        // EXTEST load: watch the captured 01 pattern leave first
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("sel_ir", 32'(tap_state), 32'd9);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("sh_ir", 32'(tap_state), 32'd11);
        for (int i = 0; i < 4; i++) begin
            obs4[i] = tdo;
            step(i == 3, 1'b0);
        end
        chk("ir_cap_bits", 32'(obs4[1:0]), 32'h1);
        step(1'b1, 1'b0);
        chk("upd_ir", 32'(tap_state), 32'd15);
        chk("upd_ir_mode", 32'(bsr_mode), 32'd0);
        step(1'b0, 1'b0);
        chk("extest_ir", 32'(ir_q), 32'd0);
        chk("extest_mode", 32'(bsr_mode), 32'd1);

        // EXTEST DR scan: count strobe cycles, tdo follows bsr_tdo
        capCnt = 0; shCnt = 0; updCnt = 0;
        pat = 32'h0000_0005;
        step(1'b1, 1'b0);
        capCnt += int'(bsr_capture);
        step(1'b0, 1'b0);
        capCnt += int'(bsr_capture);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bsr_tdo = pat[i];
            #1;
            got[i] = tdo;
            capCnt += int'(bsr_capture);
            shCnt  += int'(bsr_shift);
            step(i == 2, 1'b0);
        end
        chk("bsr_tdo_pass", 32'(got[2:0]), 32'h5);
        shCnt += int'(bsr_shift);
        step(1'b1, 1'b0);
        updCnt += int'(bsr_update);
        step(1'b0, 1'b0);
        updCnt += int'(bsr_update);
        chk("cap_count", 32'(capCnt), 32'd1);
        chk("shift_count", 32'(shCnt), 32'd3);
        chk("upd_count", 32'(updCnt), 32'd1);

        // Illegal opcode 5 behaves as BYPASS
        loadIr(4'h5);
        chk("ir_5", 32'(ir_q), 32'h5);
        chk("ir_5_mode", 32'(bsr_mode), 32'd0);
        bsr_tdo = 1'b1;
        bsrAny  = 0;
        pat     = 32'h0000_000D;   // tdi sequence 1,0,1,1
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        bsrAny += int'(bsr_capture);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            obs4[i] = tdo;
            bsrAny += int'(bsr_shift) + int'(bsr_mode);
            step(i == 3, pat[i]);
        end
        chk("bypass_delay", 32'(obs4), 32'hA);
        step(1'b0, 1'b0);
        chk("pau_dr", 32'(tap_state), 32'd6);
        bsrAny += int'(bsr_update);
        chk("bypass_no_bsr", 32'(bsrAny), 32'd0);

        // Escape from PAU_DR with five TMS=1 cycles
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("escape_tlr", 32'(tap_state), 32'd0);
        chk("escape_ir", 32'(ir_q), 32'(RESET_OP));
        step(1'b1, 1'b0);
        chk("escape_ir_hold", 32'(ir_q), 32'(RESET_OP));

        // Reset pulse after two SH_IR bits
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("mid_sh_ir", 32'(tap_state), 32'd11);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_state", 32'(tap_state), 32'd0);
        chk("mid_rst_ir", 32'(ir_q), 32'(RESET_OP));
        chk("mid_rst_oe", 32'(tdo_oe), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0);
        loadIr(4'h1);
        chk("sample_ir", 32'(ir_q), 32'h1);
        chk("sample_mode", 32'(bsr_mode), 32'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("sample_cap", 32'(bsr_capture), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1-style TAP controller with instruction register and decode. Sits directly upstream of the boundary-scan cell chain. Drives capture, shift and update strobes and the mode select into that chain, and receives the chain's serial output. It also holds the BYPASS and optional IDCODE data registers and muxes the selected register onto tdo.

Parameters:
- IR_W, 4: instruction register width (>=2).
- IDCODE_VAL, 32'h1000_563F: device ID; bit 0 must be 1.

Ports:
- clk  in  1: TCK; all state changes on rising edge.
- rst_n  in  1: asynchronous active-low reset.
- tms  in  1: test mode select, sampled on the rising edge of clk.
- tdi  in  1: serial data in. Also wired externally to the first boundary cell's shiftIN.
- tdo  out  1: serial data out.
- tdo_oe  out  1: high only in SHIFT_DR or SHIFT_IR.
- bsr_tdo  in  1: shiftOUT of the last boundary cell.
- bsr_capture  out  1: high in CAPTURE_DR when the boundary register is selected.
- bsr_shift  out  1: high in SHIFT_DR when the boundary register is selected (drives shiftDR).
- bsr_update  out  1: high in UPDATE_DR when the boundary register is selected (qualifies updateDR).
- bsr_mode  out  1: high while the current instruction is EXTEST.
- ir_q  out  IR_W: current instruction.
- tap_state  out  4: FSM state, for debug.

Behaviour:
- Reset (rst_n=0):
  - state = TEST_LOGIC_RESET.
  - ir_q = IDCODE opcode (BYPASS opcode without the optional feature).
  - All shift registers = 0.
  - All bsr_* outputs, tdo_oe and tdo = 0.
- FSM: the standard 16 states, encoded 0..15 in this order: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR. Transitions follow the 1149.1 TMS graph.
- From any state, 5 consecutive cycles with tms=1 reach TLR.
- Being in TLR forces ir_q to its reset value on every cycle spent there.
- Strobe convention: a strobe is high for the whole cycle the FSM is in the matching state. The action takes effect at the rising edge that ends that cycle. All strobes are Moore outputs decoded from the registered state.
- Opcodes:
  - EXTEST = 0 (all bits 0).
  - SAMPLE/PRELOAD = 1.
  - IDCODE = 2.
  - BYPASS = all ones.
  - Any other value decodes as BYPASS.
- IR path:
  - CAP_IR: ir_sr <= {0..., 2'b01}.
  - SH_IR: ir_sr <= {tdi, ir_sr[IR_W-1:1]}; tdo = ir_sr[0].
  - UPD_IR: ir_q <= ir_sr at the edge leaving the state. bsr_mode changes on the same edge.
- DR select: EXTEST and SAMPLE select the boundary register; IDCODE selects the ID register; everything else selects BYPASS. bsr_* strobes are gated by the boundary-register selection.
- BYPASS:
  - CAP_DR: loads 0.
  - SH_DR: loads tdi; tdo = bypass bit (exactly one cycle of delay from tdi to tdo).
- IDCODE:
  - CAP_DR: loads IDCODE_VAL.
  - SH_DR: shifts right, tdi enters the MSB; tdo = bit 0, so the ID leaves LSB first.
- Boundary register selected: tdo = bsr_tdo during SH_DR.
- Outside SH_DR and SH_IR, tdo = 0.
- tdo is combinational from registered state and therefore changes only after a rising clk edge.
- Pause and exit states hold all shift registers unchanged.
- Reset asserted mid-shift: immediate return to TLR and reset values; a partial IR shift is discarded.

Optional Feature:
- Macro: JTAG_IDCODE_EN.
- Defined: the 32-bit ID register exists; the IDCODE opcode selects it; the reset instruction is IDCODE.
- Undefined: no ID register is built; IDCODE decodes as BYPASS; the reset instruction is BYPASS.

Decomposition:
- Package jtag_pkg:
  - tap_state_t enum (4-bit, encoding as above).
  - Opcode localparams OP_EXTEST, OP_SAMPLE, OP_IDCODE, OP_BYPASS.
  - Default IR_W.
- Sub-module jtag_tap_fsm: state register and next-state logic only. Inputs clk, rst_n, tms; output tap_state_t.
- The top level holds the IR, data registers, decode and tdo mux.

Test Plan:
- Reset: assert rst_n=0 -> tap_state=0, ir_q=4'h2, bsr_mode=0, tdo_oe=0. With JTAG_IDCODE_EN undefined -> ir_q=4'hF.
- IDCODE read: after reset, tms 0,1,0,0 (RTI, SEL_DR, CAP_DR, SH_DR), then 32 shift cycles (tms=0 x31, then 1) -> tdo bits reassemble to 32'h1000_563F.
- EXTEST load: shift IR 4'h0 through CAP_IR/SH_IR/UPD_IR:
  - During SH_IR the first two tdo bits are 1, 0.
  - bsr_mode goes to 1 on the edge leaving UPD_IR.
  - A following DR scan gives bsr_capture, bsr_shift and bsr_update each high for exactly one state visit, and tdo follows bsr_tdo.
- BYPASS / illegal opcode: load 4'h5, drive tdi pattern 1,0,1,1 during SH_DR -> tdo gives 0,1,0,1 (one-cycle delay). All bsr_* stay 0 and bsr_mode=0.
- Escape: from PAU_DR hold tms=1 for 5 cycles -> tap_state=TLR, ir_q back to the reset opcode.
- Reset mid-operation: pulse rst_n low during SH_IR after 2 bits -> TLR, ir_q unchanged from its reset value, the next full scan behaves normally.
